serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  request a new subtraction; sampled on the rising edge.
REQ-005 SHALL have port i_a  input  WIDTH  minuend, sampled only on the rising edge that accepts i_start.
REQ-006 SHALL have port i_b  input  WIDTH  subtrahend, sampled only on the rising edge that accepts i_start.
REQ-007 SHALL have port o_busy  output  1  high while the subtraction is in progress (SHIFT state).
REQ-008 SHALL have port o_done  output  1  one-cycle pulse marking o_diff/o_borrow as newly valid.
REQ-009 SHALL have port o_diff  output  WIDTH  result register, i_a minus i_b modulo 2^WIDTH.
REQ-010 SHALL have port o_borrow  output  1  final borrow out, high exactly when i_a < i_b unsigned.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE: when i_start=1, SHALL load i_a and i_b into internal shift registers, clear the borrow flip-flop and the bit counter, and go to SHIFT.
REQ-013 SHIFT: each cycle SHALL process one bit pair, LSB first, with a full subtractor: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
REQ-014 SHIFT: each cycle SHALL shift d into the internal result shift register from the MSB side and register bout as the next bin.
REQ-015 SHIFT: SHALL last exactly WIDTH cycles, then go to DONE.
REQ-016 DONE entry: SHALL copy the internal result to o_diff and the final borrow to o_borrow on the same edge.
REQ-017 DONE: SHALL drive o_done=1 for exactly that one cycle.
REQ-018 DONE: on the next edge SHALL go to SHIFT if i_start=1 (accepting new operands as in REQ-012); otherwise SHALL go to IDLE.
REQ-019 Latency: with i_start accepted on edge k, o_done SHALL be high in the cycle following edge k+WIDTH.
REQ-020 Latency: o_diff and o_borrow SHALL update on edge k+WIDTH.
REQ-021 o_busy SHALL be 1 in SHIFT only; i_start SHALL be ignored while o_busy=1; operand changes during SHIFT SHALL have no effect.
REQ-022 o_diff and o_borrow SHALL hold their last result through IDLE and through any later SHIFT until the next DONE entry.
REQ-023 Wrap-around: results SHALL be modulo 2^WIDTH with no saturation; the bit counter SHALL be clog2(WIDTH)+1 bits wide so that WIDTH is counted without aliasing.

Reset
REQ-024 i_rst_n=0 SHALL immediately force: state IDLE, o_busy=0, o_done=0, o_diff=0, o_borrow=0, counter=0, shift registers=0.
REQ-025 Reset asserted mid-SHIFT SHALL abandon the operation with no o_done pulse; the first i_start after reset release SHALL start cleanly.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_OVF_EN defined: SHALL add port o_ovf  output  1, the signed two's-complement overflow flag, reset 0.
REQ-027 With SERIAL_SUBTRACTOR_OVF_EN defined: o_ovf SHALL be (a_msb != b_msb) && (diff_msb != a_msb), updated and held exactly as o_borrow.
REQ-028 Macro SERIAL_SUBTRACTOR_OVF_EN not defined: port o_ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-029 SHALL cover: i_a=0x05, i_b=0x03, start -> o_busy high 8 cycles, o_done one cycle, o_diff=0x02, o_borrow=0.
REQ-030 SHALL cover: i_a=0x03, i_b=0x05 -> o_diff=0xFE, o_borrow=1; also i_a=0x00, i_b=0x00 -> o_diff=0x00, o_borrow=0.
REQ-031 SHALL cover: i_a=0x80, i_b=0x01 -> o_diff=0x7F, o_borrow=0, o_ovf=1 (macro defined).
REQ-032 SHALL cover: i_a=0x7F, i_b=0xFF -> o_diff=0x80, o_borrow=1, o_ovf=1 (macro defined).
REQ-033 SHALL cover: i_start pulsed and i_a/i_b changed during SHIFT -> ignored, original result returned.
REQ-034 SHALL cover: i_start held high across DONE -> back-to-back operation, second o_done exactly 9 cycles after the first.
REQ-035 SHALL cover: i_rst_n low at SHIFT cycle 4 -> all outputs 0 immediately, no o_done; 0x0A-0x04 after release -> o_diff=0x06.

Source files
------------

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor: bit-serial LSB-first a-b, one bit per clock; optional
// signed overflow flag when SERIAL_SUBTRACTOR_OVF_EN is defined.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             o_borrow,
  output logic             o_ovf
`else
  output logic             o_borrow
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_d;
  logic bit_bout;

  // Full subtractor on the current LSB pair.
  always_comb begin
    bit_d    = a_q[0] ^ b_q[0] ^ bin_q;
    bit_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        bin_d = bit_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bit_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // On the final bit a_q[0]/b_q[0] hold the operand sign bits.
          ovf_d    = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
`endif
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign o_busy   = (state_q == ST_SHIFT);
  assign o_done   = (state_q == ST_DONE);
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign o_ovf    = ovf_q;
`endif

endmodule

`default_nettype wire
